// File: rtl/seq_div_defs.sv
// rtl/seq_div_defs.sv - shared state encodings and default width for the divider family
package seq_div_defs;

    localparam int DEF_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub.sv
// rtl/sub.sv - W-bit unsigned subtractor, cout=1 signals a borrow (a < b)
module sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         cout
);

    assign {cout, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - restoring unsigned sequential divider, one quotient bit per cycle
module seq_div
    import seq_div_defs::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    state_t        state, state_nxt;
    logic [N-1:0]  dq_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N-1:0]  dsr_q;
    logic [N:0]    rem_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    rem_shift, trial, rem_next;
    logic          borrow, accept, zero_div, last;

    assign ready    = (state == IDLE) || (state == DONE);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign accept   = ready && start;
    assign zero_div = (dsr_q == '0);
    assign last     = busy && (zero_div || (cnt_q == CW'(1)));

    assign rem_shift = {rem_q[N-1:0], dq_q[N-1]};
    assign rem_next  = borrow ? rem_shift : trial;

    sub #(.W(N + 1)) u_sub (
        .a    (rem_shift),
        .b    ({1'b0, dsr_q}),
        .diff (trial),
        .cout (borrow)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_q        <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dq_q  <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            cnt_q <= CW'(N);
        end else if (busy) begin
            if (zero_div) begin
                // Decided in the first RUN cycle: dq_q still holds the untouched dividend
                cnt_q       <= '0;
                quotient    <= '1;
                remainder   <= dq_q;
                div_by_zero <= 1'b1;
            end else begin
                dq_q  <= {dq_q[N-2:0], ~borrow};
                rem_q <= rem_next;
                cnt_q <= cnt_q - CW'(1);
                if (last) begin
                    quotient    <= {dq_q[N-2:0], ~borrow};
                    remainder   <= rem_next[N-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    // Partial remainder stays below the divisor, so its top bit must be clear once a result is out
    always_ff @(posedge clk) begin
        if (!rst && done) assert (rem_q[N] == 1'b0);
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - self-checking bench for seq_div: vector table, corner sequences, random vs model
module tb_seq_div;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [N-1:0] dividend, divisor;
    logic         ready, busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int lat;
    } vec_t;

    vec_t vt[6];

    seq_div #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int dz, output int lat);
        if (b == 0) begin
            q = (1 << N) - 1; r = a; dz = 1; lat = 2;
        end else begin
            q = a / b; r = a % b; dz = 0; lat = N + 1;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after acceptance
    task automatic issue(input int a, input int b);
        dividend = N'(a);
        divisor  = N'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int l0, output int lat);
        lat = l0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_check(input string tag, input int a, input int b,
                             input int q, input int r, input int dz, input int lat_exp);
        int lat;
        issue(a, b);
        wait_done(1, lat);
        chk($sformatf("%s_q", tag), int'(quotient), q);
        chk($sformatf("%s_r", tag), int'(remainder), r);
        chk($sformatf("%s_dz", tag), int'(div_by_zero), dz);
        chk($sformatf("%s_lat", tag), lat, lat_exp);
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), int'(done), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_q"}, int'(quotient), 0);
        chk({tag, "_r"}, int'(remainder), 0);
        chk({tag, "_dz"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int lat, q, r, dz, le, a, b;

        vt[0] = '{a: 100, b: 7,   q: 14,  r: 2,   dz: 0, lat: 9};
        vt[1] = '{a: 5,   b: 9,   q: 0,   r: 5,   dz: 0, lat: 9};
        vt[2] = '{a: 255, b: 1,   q: 255, r: 0,   dz: 0, lat: 9};
        vt[3] = '{a: 37,  b: 0,   q: 255, r: 37,  dz: 1, lat: 2};
        vt[4] = '{a: 0,   b: 5,   q: 0,   r: 0,   dz: 0, lat: 9};
        vt[5] = '{a: 254, b: 255, q: 0,   r: 254, dz: 0, lat: 9};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i])
            run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].lat);

        // start during RUN with different operands is ignored
        issue(100, 7);
        repeat (2) @(negedge clk);
        chk("run_ready_low", int'(ready), 0);
        dividend = 8'd200; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat);
        chk("ignore_q", int'(quotient), 14);
        chk("ignore_r", int'(remainder), 2);
        chk("ignore_lat", lat, 9);

        // back-to-back start in the DONE cycle
        issue(255, 1);
        chk("b2b_done_drop", int'(done), 0);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_q_held", int'(quotient), 14);
        chk("b2b_r_held", int'(remainder), 2);
        wait_done(1, lat);
        chk("b2b_q", int'(quotient), 255);
        chk("b2b_r", int'(remainder), 0);
        chk("b2b_lat", lat, 9);
        @(negedge clk);

        // reset in RUN cycle 4 aborts the operation
        issue(37, 0);
        wait_done(1, lat);
        @(negedge clk);
        issue(100, 7);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrun_rst");
        run_check("after_rst", 100, 7, 14, 2, 0, 9);

        // reset wins over a simultaneous start
        rst = 1'b1; dividend = 8'd9; divisor = 8'd2; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", int'(busy), 0);
        chk("rst_prio_ready", int'(ready), 1);
        @(negedge clk);
        chk("rst_prio_idle", int'(busy), 0);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            ref_div(a, b, q, r, dz, le);
            run_check($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b, q, r, dz, le);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
